// File: rtl/neuro_pkg.sv
// Shared types and constants for the synaptic current injector.
// Current values are CURR_W-bit two's-complement fixed point.
package neuro_pkg;

    localparam int CURR_W = 17;

    localparam logic signed [CURR_W-1:0] CURR_MAX = {1'b0, {(CURR_W-1){1'b1}}};
    localparam logic signed [CURR_W-1:0] CURR_MIN = {1'b1, {(CURR_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SUM   = 2'd1,
        WRITE = 2'd2
    } inj_state_t;

endpackage

// File: rtl/sat_add.sv
// Combinational W-bit signed adder that clamps to the most positive or
// most negative representable value instead of wrapping.
module sat_add #(
    parameter int W = neuro_pkg::CURR_W
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o
);

    localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic signed [W-1:0] raw;

    assign raw = a_i + b_i;

    // Overflow is only possible when both operands share a sign and the
    // wrapped result does not.
    always_comb begin
        sum_o = raw;
        if ((a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1])) begin
            sum_o = a_i[W-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/current_injector.sv
// Accumulates weighted spike events per channel over a timestep, then on tick
// adds them to the decayed currents and strobes the sum into the decay unit.
module current_injector #(
    parameter int CURR_W = neuro_pkg::CURR_W,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick,
    input  logic                     ev_valid,
    output logic                     ev_ready,
    input  logic                     ev_chan,
    input  logic signed [CURR_W-1:0] ev_weight,
    input  logic signed [CURR_W-1:0] i_prime1,
    input  logic signed [CURR_W-1:0] i_prime2,
    output logic                     write,
    output logic signed [CURR_W-1:0] curr_in1,
    output logic signed [CURR_W-1:0] curr_in2,
    output logic [CNT_W-1:0]         ev_count,
    output logic                     tick_err
);

    import neuro_pkg::inj_state_t, neuro_pkg::ACCUM, neuro_pkg::SUM, neuro_pkg::WRITE;

    inj_state_t              state_q, state_d;
    logic signed [CURR_W-1:0] acc1_q, acc1_d, acc2_q, acc2_d;
    logic signed [CURR_W-1:0] curr1_q, curr1_d, curr2_q, curr2_d;
    logic signed [CURR_W-1:0] acc1_sum, acc2_sum, curr1_sum, curr2_sum;
    logic [CNT_W-1:0]         cnt_q, cnt_d, ev_count_q, ev_count_d;
    logic                     tick_err_q, tick_err_d;
    logic                     rdy_q;
    logic                     xfer;

    sat_add #(.W(CURR_W)) u_acc1  (.a_i(acc1_q),   .b_i(ev_weight), .sum_o(acc1_sum));
    sat_add #(.W(CURR_W)) u_acc2  (.a_i(acc2_q),   .b_i(ev_weight), .sum_o(acc2_sum));
    sat_add #(.W(CURR_W)) u_curr1 (.a_i(i_prime1), .b_i(acc1_q),    .sum_o(curr1_sum));
    sat_add #(.W(CURR_W)) u_curr2 (.a_i(i_prime2), .b_i(acc2_q),    .sum_o(curr2_sum));

    // rdy_q keeps ev_ready low until the first edge after reset release.
    assign ev_ready = rdy_q && (state_q == ACCUM);
    assign xfer     = ev_valid && ev_ready;
    assign write    = (state_q == WRITE);
    assign curr_in1 = curr1_q;
    assign curr_in2 = curr2_q;
    assign ev_count = ev_count_q;
    assign tick_err = tick_err_q;

    // NOTE: every output of this block gets a default first so that no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        acc1_d     = acc1_q;
        acc2_d     = acc2_q;
        curr1_d    = curr1_q;
        curr2_d    = curr2_q;
        cnt_d      = cnt_q;
        ev_count_d = ev_count_q;
        tick_err_d = tick_err_q;
        case (state_q)
            ACCUM: begin
                if (xfer) begin
                    if (ev_chan) acc2_d = acc2_sum;
                    else         acc1_d = acc1_sum;
                    if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
                end
                if (tick) state_d = SUM;
            end
            SUM: begin
                curr1_d    = curr1_sum;
                curr2_d    = curr2_sum;
                acc1_d     = '0;
                acc2_d     = '0;
                ev_count_d = cnt_q;
                cnt_d      = '0;
                if (tick) tick_err_d = 1'b1;
                state_d    = WRITE;
            end
            WRITE: begin
                if (tick) tick_err_d = 1'b1;
                state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            acc1_q     <= '0;
            acc2_q     <= '0;
            curr1_q    <= '0;
            curr2_q    <= '0;
            cnt_q      <= '0;
            ev_count_q <= '0;
            tick_err_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc1_q     <= acc1_d;
            acc2_q     <= acc2_d;
            curr1_q    <= curr1_d;
            curr2_q    <= curr2_d;
            cnt_q      <= cnt_d;
            ev_count_q <= ev_count_d;
            tick_err_q <= tick_err_d;
            rdy_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_current_injector.sv
// Scoreboard bench: each tick pushes the model's expected commit, which is
// popped and compared when the write strobe is observed.
module tb_current_injector;

    import neuro_pkg::*;

    localparam int W  = 17;
    localparam int CW = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                tick = 1'b0;
    logic                ev_valid = 1'b0;
    logic                ev_ready;
    logic                ev_chan = 1'b0;
    logic signed [W-1:0] ev_weight = '0;
    logic signed [W-1:0] i_prime1 = '0;
    logic signed [W-1:0] i_prime2 = '0;
    logic                write;
    logic signed [W-1:0] curr_in1;
    logic signed [W-1:0] curr_in2;
    logic [CW-1:0]       ev_count;
    logic                tick_err;

    current_injector #(.CURR_W(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_chan(ev_chan), .ev_weight(ev_weight),
        .i_prime1(i_prime1), .i_prime2(i_prime2),
        .write(write), .curr_in1(curr_in1), .curr_in2(curr_in2),
        .ev_count(ev_count), .tick_err(tick_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [W-1:0] c1;
        logic signed [W-1:0] c2;
        logic [CW-1:0]       cnt;
    } exp_t;

    exp_t                sb[$];
    logic signed [W-1:0] m_acc1 = '0;
    logic signed [W-1:0] m_acc2 = '0;
    int                  m_cnt = 0;
    int                  n_tests = 0;
    int                  n_fail = 0;

    function automatic logic signed [W-1:0] clamp(input longint v);
        if (v > longint'(CURR_MAX)) return CURR_MAX;
        if (v < longint'(CURR_MIN)) return CURR_MIN;
        return v[W-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_event(input logic ch, input logic signed [W-1:0] w);
        if (ch) m_acc2 = clamp(longint'(m_acc2) + longint'(w));
        else    m_acc1 = clamp(longint'(m_acc1) + longint'(w));
        m_cnt++;
    endtask

    task automatic push_expected();
        exp_t e;
        e.c1  = clamp(longint'(i_prime1) + longint'(m_acc1));
        e.c2  = clamp(longint'(i_prime2) + longint'(m_acc2));
        e.cnt = (m_cnt > 255) ? 8'd255 : m_cnt[7:0];
        sb.push_back(e);
        m_acc1 = '0;
        m_acc2 = '0;
        m_cnt  = 0;
    endtask

    task automatic compare_commit(input string name);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            $display("FAIL %s: write pulse with empty scoreboard", name);
            n_fail++;
        end else begin
            e = sb.pop_front();
            if (curr_in1 !== e.c1 || curr_in2 !== e.c2 || ev_count !== e.cnt) begin
                $display("FAIL %s: got c1=%h c2=%h cnt=%0d, want c1=%h c2=%h cnt=%0d",
                         name, curr_in1, curr_in2, ev_count, e.c1, e.c2, e.cnt);
                n_fail++;
            end
        end
    endtask

    // Entered at posedge+1; leaves at posedge+1 with the handshake completed.
    task automatic send(input logic ch, input logic signed [W-1:0] w);
        int guard = 0;
        ev_valid = 1'b1; ev_chan = ch; ev_weight = w;
        while (!ev_ready && guard < 20) begin
            step();
            guard++;
        end
        if (guard >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL send: ev_ready stuck low, got 0 want 1");
        end
        step();
        model_event(ch, w);
        ev_valid = 1'b0;
    endtask

    // Tick (optionally with a same-cycle event) and check the SUM/WRITE timing.
    task automatic commit(input string name, input bit with_ev, input logic ch,
                          input logic signed [W-1:0] w);
        tick = 1'b1;
        if (with_ev) begin
            ev_valid = 1'b1; ev_chan = ch; ev_weight = w;
            if (ev_ready) model_event(ch, w);
        end
        push_expected();
        step();
        tick = 1'b0;
        ev_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (write !== 1'b0 || ev_ready !== 1'b0) begin
            $display("FAIL %s_sum: write=%b ready=%b, want 0 0", name, write, ev_ready);
            n_fail++;
        end
        @(negedge clk);
        n_tests++;
        if (write !== 1'b1 || ev_ready !== 1'b0) begin
            $display("FAIL %s_write: write=%b ready=%b, want 1 0", name, write, ev_ready);
            n_fail++;
        end
        if (write === 1'b1) compare_commit(name);
        @(negedge clk);
        n_tests++;
        if (write !== 1'b0 || ev_ready !== 1'b1) begin
            $display("FAIL %s_after: write=%b ready=%b, want 0 1", name, write, ev_ready);
            n_fail++;
        end
        step();
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if (curr_in1 !== '0 || curr_in2 !== '0 || ev_count !== '0 || write !== 1'b0 ||
            tick_err !== 1'b0 || ev_ready !== 1'b0) begin
            $display("FAIL reset_state: c1=%h c2=%h cnt=%0d wr=%b err=%b rdy=%b, want all 0",
                     curr_in1, curr_in2, ev_count, write, tick_err, ev_ready);
            n_fail++;
        end
        step();
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (ev_ready !== 1'b0) begin
            $display("FAIL reset_release: ev_ready=%b want 0", ev_ready);
            n_fail++;
        end
        step();
        n_tests++;
        if (ev_ready !== 1'b1) begin
            $display("FAIL reset_ready: ev_ready=%b want 1", ev_ready);
            n_fail++;
        end
    endtask

    task automatic test_basic();
        i_prime1 = 17'sh00200; i_prime2 = '0;
        send(1'b0, 17'sh00100);
        send(1'b0, 17'sh00080);
        commit("basic", 1'b0, 1'b0, '0);
        n_tests++;
        if (curr_in1 !== 17'sh00380 || ev_count !== 8'd2) begin
            $display("FAIL basic_lit: c1=%h cnt=%0d, want 00380 2", curr_in1, ev_count);
            n_fail++;
        end
    endtask

    task automatic test_same_cycle();
        i_prime1 = '0; i_prime2 = 17'sh00010;
        commit("same_cycle", 1'b1, 1'b1, -17'sh00040);
        n_tests++;
        if (curr_in2 !== -17'sh00030 || ev_count !== 8'd1) begin
            $display("FAIL same_cycle_lit: c2=%h cnt=%0d, want %h 1", curr_in2, ev_count, -17'sh00030);
            n_fail++;
        end
    endtask

    task automatic test_saturation();
        i_prime1 = 17'sh00001; i_prime2 = '0;
        send(1'b0, 17'sh0FFFF);
        send(1'b0, 17'sh0FFFF);
        commit("sat_pos", 1'b0, 1'b0, '0);
        n_tests++;
        if (curr_in1 !== 17'sh0FFFF) begin
            $display("FAIL sat_pos_lit: c1=%h want 0ffff", curr_in1);
            n_fail++;
        end
        i_prime1 = -17'sh00001;
        send(1'b0, -17'sh0FFFF);
        send(1'b0, -17'sh0FFFF);
        commit("sat_neg", 1'b0, 1'b0, '0);
        n_tests++;
        if (curr_in1 !== 17'sh10000) begin
            $display("FAIL sat_neg_lit: c1=%h want 10000", curr_in1);
            n_fail++;
        end
    endtask

    task automatic test_tick_err();
        int writes = 0;
        i_prime1 = 17'sh00007; i_prime2 = '0;
        tick = 1'b1;
        push_expected();
        step();
        step();
        tick = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (write === 1'b1) begin
                writes++;
                compare_commit("tick_err_commit");
            end
        end
        n_tests++;
        if (tick_err !== 1'b1 || writes != 1) begin
            $display("FAIL tick_err: err=%b writes=%0d, want 1 1", tick_err, writes);
            n_fail++;
        end
        step();
        send(1'b1, 17'sh00022);
        commit("tick_err_next", 1'b0, 1'b0, '0);
        n_tests++;
        if (tick_err !== 1'b1 || curr_in2 !== 17'sh00022) begin
            $display("FAIL tick_err_sticky: err=%b c2=%h, want 1 00022", tick_err, curr_in2);
            n_fail++;
        end
    endtask

    task automatic test_reset_abort();
        int writes = 0;
        i_prime1 = 17'sh00040; i_prime2 = '0;
        send(1'b0, 17'sh00011);
        tick = 1'b1;
        step();
        tick = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (curr_in1 !== '0 || curr_in2 !== '0 || ev_count !== '0 || write !== 1'b0 ||
            tick_err !== 1'b0 || ev_ready !== 1'b0) begin
            $display("FAIL abort_reset: c1=%h c2=%h cnt=%0d wr=%b err=%b rdy=%b, want all 0",
                     curr_in1, curr_in2, ev_count, write, tick_err, ev_ready);
            n_fail++;
        end
        m_acc1 = '0; m_acc2 = '0; m_cnt = 0;
        step();
        step();
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (write === 1'b1) writes++;
        end
        n_tests++;
        if (writes != 0 || ev_ready !== 1'b1) begin
            $display("FAIL abort_nowrite: writes=%0d rdy=%b, want 0 1", writes, ev_ready);
            n_fail++;
        end
        step();
        i_prime1 = '0;
        send(1'b0, 17'sh00005);
        commit("abort_restart", 1'b0, 1'b0, '0);
        n_tests++;
        if (curr_in1 !== 17'sh00005 || ev_count !== 8'd1) begin
            $display("FAIL abort_restart_lit: c1=%h cnt=%0d, want 00005 1", curr_in1, ev_count);
            n_fail++;
        end
    endtask

    task automatic test_idle();
        i_prime1 = 17'sh00123; i_prime2 = 17'sh1FF00;
        commit("idle", 1'b0, 1'b0, '0);
        n_tests++;
        if (curr_in1 !== 17'sh00123 || curr_in2 !== 17'sh1FF00 || ev_count !== 8'd0) begin
            $display("FAIL idle_lit: c1=%h c2=%h cnt=%0d, want 00123 1ff00 0",
                     curr_in1, curr_in2, ev_count);
            n_fail++;
        end
    endtask

    task automatic test_count_sat();
        i_prime1 = '0; i_prime2 = '0;
        for (int i = 0; i < 260; i++) send(i[0], 17'sh00001);
        commit("count_sat", 1'b0, 1'b0, '0);
        n_tests++;
        if (ev_count !== 8'd255) begin
            $display("FAIL count_sat_lit: cnt=%0d want 255", ev_count);
            n_fail++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_same_cycle();
        test_saturation();
        test_tick_err();
        test_reset_abort();
        test_idle();
        test_count_sat();
        n_tests++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
            n_fail++;
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/current_injector.md
CURRENT_INJECTOR -- requirements
Module: current_injector

Interface
REQ-001 Parameter CURR_W, default 17: width of every current and weight value, two's-complement signed fixed point.
REQ-002 Parameter CNT_W, default 8: width of the per-timestep event counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 tick  input  1  one-cycle pulse marking the end of a timestep.
REQ-006 ev_valid  input  1  spike event offered.
REQ-007 ev_ready  output  1  injector can accept an event this cycle.
REQ-008 ev_chan  input  1  target channel: 0 = neuron 1, 1 = neuron 2.
REQ-009 ev_weight  input  CURR_W  signed synaptic weight of the event.
REQ-010 i_prime1, i_prime2  input  CURR_W each  decayed currents returned by the decay unit.
REQ-011 write  output  1  load strobe to the decay unit.
REQ-012 curr_in1, curr_in2  output  CURR_W each  new currents for the decay unit.
REQ-013 ev_count  output  CNT_W  events accepted in the last committed timestep.
REQ-014 tick_err  output  1  sticky flag: a tick arrived while a commit was in progress.

Function
REQ-015 Use a three-state FSM: ACCUM, SUM, WRITE.
REQ-016 ACCUM: ev_ready=1. An event transfers when ev_valid && ev_ready at a rising edge.
REQ-017 On transfer: acc[ev_chan] <= sat(acc[ev_chan] + ev_weight); running event count increments, saturating at 2^CNT_W-1.
REQ-018 ACCUM -> SUM on tick. An event transferring in the same cycle as tick is included in this timestep.
REQ-019 SUM (1 cycle): ev_ready=0; curr_in1 <= sat(i_prime1 + acc1); curr_in2 <= sat(i_prime2 + acc2); acc1, acc2 cleared; ev_count <= running count; running count cleared; then -> WRITE.
REQ-020 WRITE (1 cycle): write=1, ev_ready=0, curr_in held; then -> ACCUM.
REQ-021 write is 1 only in WRITE, so it is exactly one cycle wide.
REQ-022 curr_in1, curr_in2 change only at the SUM edge and stay stable until the next commit.
REQ-023 Tick-to-write latency: write asserts 2 cycles after the edge that sampled tick.
REQ-024 A tick sampled in SUM or WRITE is dropped and sets tick_err; tick_err clears only on reset.
REQ-025 Saturating add: a positive result that overflows clamps to +(2^(CURR_W-1)-1); a negative result that overflows clamps to -(2^(CURR_W-1)).
REQ-026 ev_chan, ev_weight and ev_valid are ignored while ev_ready=0. The producer holds the event until it transfers.
REQ-027 A timestep with no events produces curr_in = i_prime, write still pulses, and ev_count=0.

Reset
REQ-028 While rst_n=0, and asynchronously on its assertion:
- state=ACCUM
- acc1, acc2, running count = 0
- curr_in1, curr_in2 = 0
- ev_count = 0
- write = 0, tick_err = 0
REQ-029 Reset asserted mid-SUM or mid-WRITE aborts the commit, with no write pulse after release.
REQ-030 ev_ready is 0 while rst_n=0 and rises on the first clk edge after release.

Structure
REQ-031 The shared package neuro_pkg holds:
- CURR_W
- the saturation constants CURR_MAX and CURR_MIN
- the FSM state enum inj_state_t (ACCUM, SUM, WRITE)
REQ-032 One combinational sub-module, sat_add, performs the CURR_W saturating signed add. It is instantiated for acc1 update, acc2 update, and each curr_in sum.

Verification
REQ-033 Events ch0 +0x00100 and ch0 +0x00080, then tick, with i_prime1=0x00200 -> curr_in1=0x00380, write 1 cycle exactly 2 cycles after tick, ev_count=2.
REQ-034 Event ch1 -0x00040 in the same cycle as tick, i_prime2=0x00010 -> curr_in2=-0x00030, event counted, ev_ready=0 for the next 2 cycles.
REQ-035 Events ch0 +0x0FFFF twice, i_prime1=0x00001 -> curr_in1=0x0FFFF (saturated). Mirror case with negative weights -> 0x10000 (-65536).
REQ-036 Tick again in the cycle after a tick (state SUM) -> tick_err=1 and stays 1, exactly one write pulse, next timestep unaffected.
REQ-037 Tick, then rst_n=0 during SUM -> no write pulse, all outputs 0; after release ev_ready=1 and accumulation restarts from 0.
REQ-038 Tick with no events, i_prime1=0x00123, i_prime2=0x1FF00 -> curr_in1=0x00123, curr_in2=0x1FF00, ev_count=0, write pulses once.
